// File: rtl/mem_arbiter32.sv
// mem_arbiter32: shares one 32-bit memory bus between the I (fetch) and D (load/store) ports and
// steers in-order responses through an owner FIFO. Define MEMARB_RR_EN for round-robin arbitration.
`timescale 1ns/1ps
module mem_arbiter32 #(
  parameter int unsigned C_OUTSTANDING_X = 2,
  parameter int unsigned C_STARVE_LIMIT  = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clk_en_i,
  input  logic        ireqvalid_i,
  output logic        ireqready_o,
  input  logic [1:0]  ireqhpl_i,
  input  logic [31:0] ireqaddr_i,
  output logic        irspvalid_o,
  input  logic        irspready_i,
  output logic        irsprerr_o,
  output logic [31:0] irspdata_o,
  input  logic        dreqvalid_i,
  output logic        dreqready_o,
  input  logic [1:0]  dreqhpl_i,
  input  logic [31:0] dreqaddr_i,
  input  logic        dreqwr_i,
  input  logic [3:0]  dreqmask_i,
  input  logic [31:0] dreqwdata_i,
  output logic        drspvalid_o,
  input  logic        drspready_i,
  output logic        drsprerr_o,
  output logic [31:0] drspdata_o,
  output logic        mreqvalid_o,
  input  logic        mreqready_i,
  output logic [1:0]  mreqhpl_o,
  output logic [31:0] mreqaddr_o,
  output logic        mreqwr_o,
  output logic [3:0]  mreqmask_o,
  output logic [31:0] mreqwdata_o,
  input  logic        mrspvalid_i,
  output logic        mrspready_o,
  input  logic        mrsprerr_i,
  input  logic [31:0] mrspdata_i,
  output logic        spurious_o
);

  localparam int unsigned DEPTH = 1 << C_OUTSTANDING_X;
  localparam int unsigned PTR_W = C_OUTSTANDING_X;
  localparam int unsigned LVL_W = C_OUTSTANDING_X + 1;

  logic [DEPTH-1:0] owner_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             owner_full;
  logic             owner_empty;
  logic             owner_head;
  logic             sel_d;
  logic             accept;
  logic             pop;

  assign owner_full  = (level_q == LVL_W'(DEPTH));
  assign owner_empty = (level_q == '0);
  assign owner_head  = owner_q[rd_ptr_q];

`ifdef MEMARB_RR_EN
  // Last-grant bit (1 = D); on contention the other requester wins.
  logic last_d_q;

  assign sel_d = dreqvalid_i & ~(ireqvalid_i & last_d_q);

  always_ff @(posedge clk_i) begin : last_grant
    if (reset_i) begin
      last_d_q <= 1'b0;
    end else if (clk_en_i && accept) begin
      last_d_q <= sel_d;
    end
  end
`else
  // D has priority unless I has been held off for C_STARVE_LIMIT cycles.
  logic [3:0] starve_cnt_q;
  logic       starve;

  assign starve = (starve_cnt_q >= 4'(C_STARVE_LIMIT));
  assign sel_d  = dreqvalid_i & ~(ireqvalid_i & starve);

  always_ff @(posedge clk_i) begin : starve_counter
    if (reset_i) begin
      starve_cnt_q <= '0;
    end else if (clk_en_i) begin
      if (ireqvalid_i && !ireqready_o) begin
        if (starve_cnt_q != 4'hF) begin
          starve_cnt_q <= starve_cnt_q + 4'd1;
        end
      end else begin
        starve_cnt_q <= '0;
      end
    end
  end
`endif

  // Request payload mux; an I fetch is always a full-word read.
  always_comb begin : req_mux
    mreqhpl_o   = ireqhpl_i;
    mreqaddr_o  = ireqaddr_i;
    mreqwr_o    = 1'b0;
    mreqmask_o  = 4'hF;
    mreqwdata_o = '0;
    if (sel_d) begin
      mreqhpl_o   = dreqhpl_i;
      mreqaddr_o  = dreqaddr_i;
      mreqwr_o    = dreqwr_i;
      mreqmask_o  = dreqmask_i;
      mreqwdata_o = dreqwdata_i;
    end
  end

  assign mreqvalid_o = (ireqvalid_i | dreqvalid_i) & ~owner_full;
  assign accept      = mreqvalid_o & mreqready_i;
  assign ireqready_o = accept & ~sel_d;
  assign dreqready_o = accept & sel_d;

  // Responses follow the FIFO head; with nothing outstanding they are sunk.
  assign irspvalid_o = mrspvalid_i & ~owner_empty & ~owner_head;
  assign drspvalid_o = mrspvalid_i & ~owner_empty & owner_head;
  assign mrspready_o = owner_empty ? 1'b1 : (owner_head ? drspready_i : irspready_i);
  assign irsprerr_o  = mrsprerr_i;
  assign drsprerr_o  = mrsprerr_i;
  assign irspdata_o  = mrspdata_i;
  assign drspdata_o  = mrspdata_i;
  assign pop         = mrspvalid_i & mrspready_o & ~owner_empty;

  always_ff @(posedge clk_i) begin : owner_fifo
    if (reset_i) begin
      owner_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      spurious_o <= 1'b0;
    end else if (clk_en_i) begin
      if (accept) begin
        owner_q[wr_ptr_q] <= sel_d;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (accept && !pop) begin
        level_q <= level_q + LVL_W'(1);
      end else if (!accept && pop) begin
        level_q <= level_q - LVL_W'(1);
      end
      spurious_o <= mrspvalid_i & owner_empty;
    end
  end

endmodule

// File: tb/tb_mem_arbiter32.sv
// Scoreboard bench for mem_arbiter32: directed stimulus pushes expected requests/responses,
// a negedge monitor pops and compares on every handshake; a small memory model answers requests.
`timescale 1ns/1ps
module tb_mem_arbiter32;

  typedef struct packed {
    logic        own_d;
    logic        irdy;
    logic [1:0]  hpl;
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        rerr;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset_i, clk_en_i;
  logic        ireqvalid_i, ireqready_o, irspvalid_o, irspready_i, irsprerr_o;
  logic [1:0]  ireqhpl_i;
  logic [31:0] ireqaddr_i, irspdata_o;
  logic        dreqvalid_i, dreqready_o, dreqwr_i, drspvalid_o, drspready_i, drsprerr_o;
  logic [1:0]  dreqhpl_i;
  logic [31:0] dreqaddr_i, dreqwdata_i, drspdata_o;
  logic [3:0]  dreqmask_i;
  logic        mreqvalid_o, mreqready_i, mreqwr_o, mrspvalid_i, mrspready_o, mrsprerr_i;
  logic [1:0]  mreqhpl_o;
  logic [31:0] mreqaddr_o, mreqwdata_o, mrspdata_i;
  logic [3:0]  mreqmask_o;
  logic        spurious_o;

  req_t exp_req[$];
  rsp_t exp_irsp[$];
  rsp_t exp_drsp[$];
  rsp_t mem_q[$];

  int          checks = 0;
  int          errors = 0;
  int          acc_cnt = 0;
  int          spur_cnt = 0;
  logic        mem_hold = 1'b0;
  int          mem_release_req = 0;
  logic        mem_fixed = 1'b0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  mem_arbiter32 #(.C_OUTSTANDING_X(2), .C_STARVE_LIMIT(4)) dut (
    .clk_i(clk), .reset_i(reset_i), .clk_en_i(clk_en_i),
    .ireqvalid_i(ireqvalid_i), .ireqready_o(ireqready_o), .ireqhpl_i(ireqhpl_i),
    .ireqaddr_i(ireqaddr_i), .irspvalid_o(irspvalid_o), .irspready_i(irspready_i),
    .irsprerr_o(irsprerr_o), .irspdata_o(irspdata_o),
    .dreqvalid_i(dreqvalid_i), .dreqready_o(dreqready_o), .dreqhpl_i(dreqhpl_i),
    .dreqaddr_i(dreqaddr_i), .dreqwr_i(dreqwr_i), .dreqmask_i(dreqmask_i),
    .dreqwdata_i(dreqwdata_i), .drspvalid_o(drspvalid_o), .drspready_i(drspready_i),
    .drsprerr_o(drsprerr_o), .drspdata_o(drspdata_o),
    .mreqvalid_o(mreqvalid_o), .mreqready_i(mreqready_i), .mreqhpl_o(mreqhpl_o),
    .mreqaddr_o(mreqaddr_o), .mreqwr_o(mreqwr_o), .mreqmask_o(mreqmask_o),
    .mreqwdata_o(mreqwdata_o), .mrspvalid_i(mrspvalid_i), .mrspready_o(mrspready_o),
    .mrsprerr_i(mrsprerr_i), .mrspdata_i(mrspdata_i), .spurious_o(spurious_o)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic chk_req(input req_t act, input req_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL mreq: got %h, expected %h", act, exp);
    end
  endtask

  task automatic chk_rsp(input string name, input rsp_t act, input rsp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] val);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected transfer 0x%h, expected none", name, val);
  endtask

  function automatic req_t mk_i(input logic [31:0] addr, input logic [1:0] hpl);
    mk_i = '{own_d: 1'b0, irdy: 1'b1, hpl: hpl, addr: addr, wr: 1'b0, mask: 4'hF, wdata: 32'h0};
  endfunction

  function automatic req_t mk_d(input logic [31:0] addr, input logic [1:0] hpl, input logic wr,
                                input logic [3:0] mask, input logic [31:0] wdata);
    mk_d = '{own_d: 1'b1, irdy: 1'b0, hpl: hpl, addr: addr, wr: wr, mask: mask, wdata: wdata};
  endfunction

  function automatic rsp_t mk_rsp(input logic rerr, input logic [31:0] data);
    mk_rsp = '{rerr: rerr, data: data};
  endfunction

  // Memory model: answers each accepted request one cycle later, in order.
  initial begin : mem_model
    logic        acc, popped;
    logic [31:0] a;
    int          released;
    rsp_t        r;
    released    = 0;
    mrspvalid_i = 1'b0;
    mrsprerr_i  = 1'b0;
    mrspdata_i  = '0;
    forever begin
      @(negedge clk);
      acc    = mreqvalid_o & mreqready_i;
      popped = mrspvalid_i & mrspready_o;
      a      = mreqaddr_o;
      @(posedge clk);
      #1;
      if (popped) begin
        void'(mem_q.pop_front());
        if (mem_hold) released++;
      end
      if (acc) begin
        r.rerr = (a == err_addr);
        r.data = mem_fixed ? 32'h0000_0013 : (a ^ 32'hA5A5_0000);
        mem_q.push_back(r);
      end
      if (mem_q.size() != 0 && (!mem_hold || released < mem_release_req)) begin
        mrspvalid_i = 1'b1;
        mrsprerr_i  = mem_q[0].rerr;
        mrspdata_i  = mem_q[0].data;
      end else begin
        mrspvalid_i = 1'b0;
        mrsprerr_i  = 1'b0;
        mrspdata_i  = '0;
      end
    end
  end

  // Monitor: compares every handshake against the scoreboard queues.
  initial begin : monitor
    req_t act_req;
    forever begin
      @(negedge clk);
      if (mreqvalid_o && mreqready_i) begin
        acc_cnt++;
        act_req = {dreqready_o, ireqready_o, mreqhpl_o, mreqaddr_o, mreqwr_o, mreqmask_o, mreqwdata_o};
        if (exp_req.size() == 0) unexpected("mreq", mreqaddr_o);
        else chk_req(act_req, exp_req.pop_front());
      end
      if (irspvalid_o && irspready_i) begin
        if (exp_irsp.size() == 0) unexpected("irsp", irspdata_o);
        else chk_rsp("irsp", {irsprerr_o, irspdata_o}, exp_irsp.pop_front());
      end
      if (drspvalid_o && drspready_i) begin
        if (exp_drsp.size() == 0) unexpected("drsp", drspdata_o);
        else chk_rsp("drsp", {drsprerr_o, drspdata_o}, exp_drsp.pop_front());
      end
      if (spurious_o === 1'b1) spur_cnt++;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_req.size() + exp_irsp.size() + exp_drsp.size() + mem_q.size()) != 0 && n < 200) begin
      step();
      n++;
    end
    step();
    chk32("drain", 32'(exp_req.size() + exp_irsp.size() + exp_drsp.size() + mem_q.size()), 32'd0);
  endtask

  task automatic send_i(input logic [31:0] addr, input logic [1:0] hpl, output int lat);
    exp_req.push_back(mk_i(addr, hpl));
    ireqvalid_i = 1'b1;
    ireqaddr_i  = addr;
    ireqhpl_i   = hpl;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ireqready_o && lat < 50);
    chk32("i_accept", 32'(ireqready_o), 32'd1);
    step();
    ireqvalid_i = 1'b0;
  endtask

  task automatic send_d(input logic [31:0] addr, input logic [1:0] hpl, input logic wr,
                        input logic [3:0] mask, input logic [31:0] wdata);
    int lat = 0;
    exp_req.push_back(mk_d(addr, hpl, wr, mask, wdata));
    dreqvalid_i = 1'b1;
    dreqaddr_i  = addr;
    dreqhpl_i   = hpl;
    dreqwr_i    = wr;
    dreqmask_i  = mask;
    dreqwdata_i = wdata;
    do begin
      @(negedge clk);
      lat++;
    end while (!dreqready_o && lat < 50);
    chk32("d_accept", 32'(dreqready_o), 32'd1);
    step();
    dreqvalid_i = 1'b0;
  endtask

  initial begin : stimulus
    int lat, acc0, spur0;
    reset_i = 1'b1; clk_en_i = 1'b1;
    ireqvalid_i = 1'b0; ireqhpl_i = '0; ireqaddr_i = '0; irspready_i = 1'b1;
    dreqvalid_i = 1'b0; dreqhpl_i = '0; dreqaddr_i = '0; dreqwr_i = 1'b0;
    dreqmask_i = '0; dreqwdata_i = '0; drspready_i = 1'b1;
    mreqready_i = 1'b1;

    // Reset state
    step(); step();
    @(negedge clk);
    chk32("rst_mreqvalid", 32'(mreqvalid_o), 32'd0);
    chk32("rst_ireqready", 32'(ireqready_o), 32'd0);
    chk32("rst_dreqready", 32'(dreqready_o), 32'd0);
    chk32("rst_irspvalid", 32'(irspvalid_o), 32'd0);
    chk32("rst_drspvalid", 32'(drspvalid_o), 32'd0);
    chk32("rst_spurious", 32'(spurious_o), 32'd0);
    chk32("rst_mrspready", 32'(mrspready_o), 32'd1);
    step();
    reset_i = 1'b0;
    step();

    // I-only stream, fixed data 0x13
    mem_fixed = 1'b1;
    spur0 = spur_cnt;
    for (int k = 0; k < 4; k++) begin
      exp_irsp.push_back(mk_rsp(1'b0, 32'h0000_0013));
      send_i(32'h40 + 32'(k), 2'd1, lat);
      chk32("i_stream_lat", 32'(lat), 32'd1);
    end
    wait_idle();
    mem_fixed = 1'b0;
    chk32("i_stream_spurious", 32'(spur_cnt - spur0), 32'd0);

    // Both requesters valid for 10 cycles
    acc0 = acc_cnt;
    for (int k = 0; k < 10; k++) begin
`ifdef MEMARB_RR_EN
      if (k % 2 == 0) begin
`else
      if (k % 5 != 4) begin
`endif
        exp_req.push_back(mk_d(32'h2000, 2'd3, 1'b1, 4'b1100, 32'h1234_5678));
        exp_drsp.push_back(mk_rsp(1'b0, 32'hA5A5_2000));
      end else begin
        exp_req.push_back(mk_i(32'h1000, 2'd0));
        exp_irsp.push_back(mk_rsp(1'b0, 32'hA5A5_1000));
      end
    end
    ireqvalid_i = 1'b1; ireqaddr_i = 32'h1000; ireqhpl_i = 2'd0;
    dreqvalid_i = 1'b1; dreqaddr_i = 32'h2000; dreqhpl_i = 2'd3;
    dreqwr_i = 1'b1; dreqmask_i = 4'b1100; dreqwdata_i = 32'h1234_5678;
    repeat (10) step();
    ireqvalid_i = 1'b0;
    dreqvalid_i = 1'b0;
    chk32("arb_accepts", 32'(acc_cnt - acc0), 32'd10);
    wait_idle();

    // Owner FIFO full: responses withheld
    mem_hold = 1'b1;
    acc0 = acc_cnt;
    for (int k = 0; k < 5; k++) begin
      exp_req.push_back(mk_i(32'h3000, 2'd2));
      exp_irsp.push_back(mk_rsp(1'b0, 32'hA5A5_3000));
    end
    ireqvalid_i = 1'b1; ireqaddr_i = 32'h3000; ireqhpl_i = 2'd2;
    repeat (8) step();
    @(negedge clk);
    chk32("full_accepts", 32'(acc_cnt - acc0), 32'd4);
    chk32("full_mreqvalid", 32'(mreqvalid_o), 32'd0);
    chk32("full_ireqready", 32'(ireqready_o), 32'd0);
    chk32("full_dreqready", 32'(dreqready_o), 32'd0);
    mem_release_req = mem_release_req + 1;
    repeat (6) step();
    @(negedge clk);
    chk32("full_release_accepts", 32'(acc_cnt - acc0), 32'd5);
    chk32("full_again_mreqvalid", 32'(mreqvalid_o), 32'd0);
    step();
    ireqvalid_i = 1'b0;
    mem_hold = 1'b0;
    wait_idle();

    // D write then I read, second response errors
    err_addr = 32'h200;
    exp_drsp.push_back(mk_rsp(1'b0, 32'hA5A5_0100));
    exp_irsp.push_back(mk_rsp(1'b1, 32'hA5A5_0200));
    send_d(32'h100, 2'd2, 1'b1, 4'b0011, 32'hDEAD_BEEF);
    send_i(32'h200, 2'd1, lat);
    wait_idle();
    err_addr = 32'hFFFF_FFFF;

    // D response back-pressured
    drspready_i = 1'b0;
    exp_drsp.push_back(mk_rsp(1'b0, 32'hA5A5_0300));
    send_d(32'h300, 2'd0, 1'b0, 4'hF, 32'h0);
    repeat (2) step();
    @(negedge clk);
    chk32("bp_drspvalid", 32'(drspvalid_o), 32'd1);
    chk32("bp_mrspready", 32'(mrspready_o), 32'd0);
    chk32("bp_drspdata", drspdata_o, 32'hA5A5_0300);
    chk32("bp_irspvalid", 32'(irspvalid_o), 32'd0);
    step();
    drspready_i = 1'b1;
    wait_idle();

    // Reset with two outstanding; late responses must be dropped
    mem_hold = 1'b1;
    send_i(32'h400, 2'd0, lat);
    send_d(32'h500, 2'd1, 1'b0, 4'hF, 32'h0);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    spur0 = spur_cnt;
    mem_hold = 1'b0;
    repeat (6) step();
    chk32("rst_spurious_pulses", 32'(spur_cnt - spur0), 32'd2);
    chk32("rst_mem_drained", 32'(mem_q.size()), 32'd0);

    // Normal traffic after reset
    exp_irsp.push_back(mk_rsp(1'b0, 32'hA5A5_0600));
    send_i(32'h600, 2'd3, lat);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
